// File: rtl/aes_byte_serializer.sv
// Double-buffered serializer: 128-bit cipher blocks in, MSB-first bytes out.
// Optional macro BYTE_COUNT_EN adds a free-running 32-bit byte_count output.
module aes_byte_serializer #(
  parameter int BLOCK_W = 128,
  parameter int BYTE_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic [BYTE_W-1:0]  byte_data,
  output logic               byte_last,
  output logic               busy
`ifdef BYTE_COUNT_EN
  ,
  output logic [31:0]        byte_count
`endif
);

  localparam int NBYTES = BLOCK_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_next;
  logic [BLOCK_W-1:0] active, active_next;
  logic [BLOCK_W-1:0] pending, pending_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic               pending_full, pending_full_next;
  logic               blk_accept;
  logic               byte_hs;

  assign blk_accept = blk_valid && blk_ready;
  assign byte_hs    = (state == SHIFT) && byte_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      active       <= '0;
      pending      <= '0;
      idx          <= '0;
      pending_full <= 1'b0;
      blk_ready    <= 1'b0;
    end else begin
      state        <= state_next;
      active       <= active_next;
      pending      <= pending_next;
      idx          <= idx_next;
      pending_full <= pending_full_next;
      blk_ready    <= !pending_full_next;
    end
  end

  // A new block skips the pending slot when the last byte leaves with nothing queued.
  always_comb begin
    logic direct_load;
    state_next        = state;
    active_next       = active;
    pending_next      = pending;
    idx_next          = idx;
    pending_full_next = pending_full;
    direct_load       = 1'b0;
    case (state)
      IDLE: begin
        if (blk_accept) begin
          active_next = blk_data;
          idx_next    = '0;
          state_next  = SHIFT;
          direct_load = 1'b1;
        end
      end
      SHIFT: begin
        if (byte_hs) begin
          if (idx != LAST_IDX) begin
            active_next = active << BYTE_W;
            idx_next    = idx + IDX_W'(1);
          end else if (pending_full) begin
            active_next       = pending;
            idx_next          = '0;
            pending_full_next = 1'b0;
          end else if (blk_accept) begin
            active_next = blk_data;
            idx_next    = '0;
            direct_load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (blk_accept && !direct_load) begin
      pending_next      = blk_data;
      pending_full_next = 1'b1;
    end
  end

  always_comb begin
    byte_valid = (state == SHIFT);
    byte_data  = (state == SHIFT) ? active[BLOCK_W-1 -: BYTE_W] : '0;
    byte_last  = (state == SHIFT) && (idx == LAST_IDX);
    busy       = (state == SHIFT) || pending_full;
  end

`ifdef BYTE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_count <= '0;
    end else if (byte_hs) begin
      byte_count <= byte_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_byte_serializer.sv
// Testbench for aes_byte_serializer: vector table plus multi-cycle sequences,
// with a byte scoreboard filled on every block accept.
module tb_aes_byte_serializer;

  logic         clk;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         byte_valid;
  logic         byte_ready;
  logic [7:0]   byte_data;
  logic         byte_last;
  logic         busy;
`ifdef BYTE_COUNT_EN
  logic [31:0]  byte_count;
`endif

  aes_byte_serializer #(.BLOCK_W(128), .BYTE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .busy       (busy)
`ifdef BYTE_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [127:0] blk;
    bit           alt;
    int           exp_cycles;
    logic [7:0]   exp_first;
  } vec_t;

  exp_t   sb_q[$];
  exp_t   sb_e;
  vec_t   vecs[3];
  int     n_checks = 0;
  int     n_fail   = 0;
  logic [127:0] blk_a, blk_b, blk_c, blk_d, blk_e, blk_f, blk_g;
  int     n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after the rising edge, so the falling edge sees what the next edge will sample.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (byte_valid && byte_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_unexpected: got byte %0h expected none", byte_data);
        end else begin
          sb_e = sb_q.pop_front();
          checkOutput("sb_byte", {120'd0, byte_data}, {120'd0, sb_e.data});
          checkOutput("sb_last", {127'd0, byte_last}, {127'd0, sb_e.last});
        end
      end
      if (blk_valid && blk_ready) begin
        for (int i = 0; i < 16; i++) begin
          sb_q.push_back({blk_data[127-8*i -: 8], (i == 15)});
        end
      end
    end
  end

  task automatic applyReset();
    rst_n      = 1'b0;
    blk_valid  = 1'b0;
    byte_ready = 1'b0;
    blk_data   = '0;
    tick();
    tick();
    checkOutput("rst_byte_valid", byte_valid, 0);
    checkOutput("rst_byte_last", byte_last, 0);
    checkOutput("rst_byte_data", byte_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_blk_ready", blk_ready, 0);
    rst_n = 1'b1;
    checkOutput("rst_release_ready_low", blk_ready, 0);
    tick();
    checkOutput("rst_release_ready_high", blk_ready, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int         cyc;
    int         hs;
    bit         done;
    bit         stall;
    logic [7:0] held;
    blk_data   = v.blk;
    blk_valid  = 1'b1;
    byte_ready = 1'b0;
    checkOutput("vec_blk_ready", blk_ready, 1);
    tick();
    blk_valid = 1'b0;
    checkOutput("vec_first_valid", byte_valid, 1);
    checkOutput("vec_first_byte", byte_data, v.exp_first);
    cyc  = 0;
    hs   = 0;
    done = 1'b0;
    while (!done && cyc < 100) begin
      byte_ready = v.alt ? ((cyc % 2) == 1) : 1'b1;
      held  = byte_data;
      stall = byte_valid && !byte_ready;
      if (byte_valid && byte_ready) begin
        hs++;
        if (byte_last) done = 1'b1;
      end
      tick();
      cyc++;
      if (stall) checkOutput("vec_stall_hold", byte_data, held);
    end
    byte_ready = 1'b0;
    checkOutput("vec_handshakes", hs, 16);
    checkOutput("vec_drain_cycles", cyc, v.exp_cycles);
    checkOutput("vec_idle_valid", byte_valid, 0);
    checkOutput("vec_idle_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    blk_a = {16{8'h0F}};
    blk_b = {16{8'hF0}};
    blk_c = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
    blk_d = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;
    blk_e = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
    blk_f = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    blk_g = 128'h5A5B5C5D5E5F60616263646566676869;
    vecs[0] = '{128'h00112233445566778899AABBCCDDEEFF, 1'b0, 16, 8'h00};
    vecs[1] = '{128'h0123456789ABCDEFFEDCBA9876543210, 1'b1, 32, 8'h01};
    vecs[2] = '{128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b0, 16, 8'h0F};

    applyReset();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] back-to-back blocks");
    blk_data   = blk_a;
    blk_valid  = 1'b1;
    byte_ready = 1'b1;
    tick();
    blk_data = blk_b;
    tick();
    blk_valid = 1'b0;
    checkOutput("b2b_ready_pending", blk_ready, 0);
    checkOutput("b2b_busy", busy, 1);
    n = 1;
    while (byte_valid && n < 64) begin
      tick();
      n++;
    end
    checkOutput("b2b_valid_cycles", n, 32);
    checkOutput("b2b_ready_after", blk_ready, 1);
    checkOutput("b2b_busy_after", busy, 0);
    byte_ready = 1'b0;

    $display("[TB] three blocks with downstream stalled");
    blk_data  = blk_c;
    blk_valid = 1'b1;
    tick();
    blk_data = blk_d;
    tick();
    checkOutput("stall3_ready_low", blk_ready, 0);
    checkOutput("stall3_busy", busy, 1);
    blk_data = blk_e;
    tick();
    tick();
    checkOutput("stall3_third_held", blk_ready, 0);
    checkOutput("stall3_byte_hold", byte_data, blk_c[127:120]);
    byte_ready = 1'b1;
    n = 0;
    while (!blk_ready && n < 40) begin
      tick();
      n++;
    end
    checkOutput("stall3_accept_gap", n, 16);
    tick();
    blk_valid = 1'b0;
    checkOutput("stall3_e_pending", blk_ready, 0);
    n = 0;
    while (byte_valid && n < 80) begin
      tick();
      n++;
    end
    checkOutput("stall3_drain", n, 31);
    byte_ready = 1'b0;

    $display("[TB] reset in the middle of a block");
    blk_data   = blk_f;
    blk_valid  = 1'b1;
    byte_ready = 1'b1;
    tick();
    blk_valid = 1'b0;
    repeat (6) tick();
    checkOutput("midrst_byte6", byte_data, blk_f[79:72]);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_valid", byte_valid, 0);
    checkOutput("midrst_ready", blk_ready, 0);
    checkOutput("midrst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_ready_back", blk_ready, 1);
    checkOutput("midrst_no_partial", byte_valid, 0);
    blk_data  = blk_g;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    checkOutput("midrst_next_first", byte_data, blk_g[127:120]);
    n = 0;
    while (byte_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("midrst_next_drain", n, 16);
    byte_ready = 1'b0;

`ifdef BYTE_COUNT_EN
    $display("[TB] byte counter");
    applyReset();
    applyStimulus(vecs[0]);
    applyStimulus(vecs[2]);
    checkOutput("count_two_blocks", byte_count, 32);
    force dut.byte_count = 32'hFFFF_FFFF;
    #1;
    release dut.byte_count;
    blk_data   = blk_a;
    blk_valid  = 1'b1;
    tick();
    blk_valid  = 1'b0;
    byte_ready = 1'b1;
    tick();
    checkOutput("count_wrap", byte_count, 0);
    n = 0;
    while (byte_valid && n < 40) begin
      tick();
      n++;
    end
    byte_ready = 1'b0;
`endif

    tick();
    checkOutput("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
